// File: rtl/seg_display_pkg.sv
// -----------------------------------------------------------------------------
// seg_display_pkg
// Shared definitions for the multiplexed 7-segment display driver:
//   - segment bit positions inside a segment byte {a,b,c,d,e,f,g,dp}
//   - 16-entry hex-to-segment table (active-high, dp bit clear)
//   - digits-per-bank helper
// -----------------------------------------------------------------------------
package seg_display_pkg;

    // Bit index of each segment within a segment byte.
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // HEX_SEG[n] is the active-high pattern for hex digit n (element 0 is
    // the rightmost entry of the concatenation).
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h9E, 8'h7A, 8'h9C,   // F E d C
        8'h3E, 8'hEE, 8'hF6, 8'hFE,   // b A 9 8
        8'hE0, 8'hBE, 8'hB6, 8'h66,   // 7 6 5 4
        8'hF2, 8'hDA, 8'h60, 8'hFC    // 3 2 1 0
    };

    // Digits driven by each segment bank.
    function automatic int calc_dpb(input int num_digits, input int banks);
        return num_digits / banks;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational hex-to-7-segment decoder for one digit.
//   hex   : 4-bit digit value
//   blank : 1 forces all of a..g off
//   dp    : lights the decimal point (independent of blank)
//   seg   : active-high segments {a,b,c,d,e,f,g,dp}
// -----------------------------------------------------------------------------
module seg7_decode
    import seg_display_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       blank,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        seg         = blank ? 8'h00 : HEX_SEG[hex];
        seg[SEG_DP] = seg[SEG_DP] | dp;
    end

endmodule

// File: rtl/seg_scan_display.sv
// -----------------------------------------------------------------------------
// seg_scan_display
// Multiplexed, parametrised 7-segment driver with internal scan prescaler,
// frame-coherent input snapshot, leading-zero blanking, per-digit decimal
// points, 8-level PWM brightness and selectable output polarity.
//
// Ports:
//   clk, rst    : system clock, asynchronous active-high reset
//   en          : display enable (0 = all selects inactive)
//   data_in     : hex word, digit i = data_in[4i+3:4i]
//   dp_mask     : bit i lights the dp of digit i
//   blank_en    : leading-zero blanking enable
//   brightness  : duty level 0..7 (7 = full on)
//   seg_cs      : digit selects, one active per bank at most
//   seg_data    : bank b segments at [8b+7:8b], {a,b,c,d,e,f,g,dp}
//   frame_tick  : one-cycle pulse in the first cycle of a new snapshot's frame
// -----------------------------------------------------------------------------
module seg_scan_display
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int BANKS          = 2,
    parameter int DIV_LOG2       = 16,
    parameter int CS_ACTIVE_LOW  = 0,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_en,
    input  logic [2:0]              brightness,
    output logic [NUM_DIGITS-1:0]   seg_cs,
    output logic [8*BANKS-1:0]      seg_data,
    output logic                    frame_tick
);

    localparam int DPB   = calc_dpb(NUM_DIGITS, BANKS);
    localparam int IDX_W = (DPB > 1) ? $clog2(DPB) : 1;

    localparam logic [DIV_LOG2-1:0]   P_MAX   = '1;
    localparam logic [IDX_W-1:0]      IDX_MAX = IDX_W'(DPB - 1);
    localparam logic [NUM_DIGITS-1:0] CS_OFF  = (CS_ACTIVE_LOW  != 0) ? '1 : '0;
    localparam logic [8*BANKS-1:0]    SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

    logic [DIV_LOG2-1:0]     p_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [4*NUM_DIGITS-1:0] snap_data_reg;
    logic [NUM_DIGITS-1:0]   snap_dp_reg;
    logic                    snap_blank_reg;
    logic                    frame_tick_reg;
    logic [NUM_DIGITS-1:0]   seg_cs_reg;
    logic [8*BANKS-1:0]      seg_data_reg;

    logic                    frame_end;
    logic                    duty_on;
    logic [NUM_DIGITS-1:0]   digit_zero;
    logic [NUM_DIGITS-1:0]   tail_zero;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic [NUM_DIGITS-1:0]   seg_cs_next;
    logic [8*BANKS-1:0]      seg_data_next;

    assign frame_end = (p_reg == P_MAX) && (idx_reg == IDX_MAX);

    // PWM: the top three prescaler bits split each slot into eighths.
    assign duty_on = (p_reg[DIV_LOG2-1 -: 3] <= brightness);

    // tail_zero[i] = snapshot digits i..NUM_DIGITS-1 are all zero.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
            assign digit_zero[gi] = (snap_data_reg[4*gi +: 4] == 4'h0);
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign tail_zero[gi] = digit_zero[gi];
            end else begin : g_chain
                assign tail_zero[gi] = digit_zero[gi] & tail_zero[gi+1];
            end
            if (gi == 0) begin : g_d0
                assign blank_vec[gi] = 1'b0;        // units digit always shown
            end else begin : g_dn
                assign blank_vec[gi] = snap_blank_reg & tail_zero[gi];
            end
        end
    endgenerate

    // Per bank: pick the digit addressed by idx, decode it, build its selects.
    generate
        for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
            logic [3:0]     sel_hex;
            logic           sel_blank;
            logic           sel_dp;
            logic [DPB-1:0] cs_bank;
            logic [7:0]     bank_seg;

            always_comb begin
                sel_hex   = 4'h0;
                sel_blank = 1'b0;
                sel_dp    = 1'b0;
                cs_bank   = '0;
                for (int k = 0; k < DPB; k++) begin
                    if (idx_reg == IDX_W'(k)) begin
                        sel_hex    = snap_data_reg[4*(gi*DPB + k) +: 4];
                        sel_blank  = blank_vec[gi*DPB + k];
                        sel_dp     = snap_dp_reg[gi*DPB + k];
                        cs_bank[k] = en & duty_on;
                    end
                end
            end

            seg7_decode u_decode (
                .hex   (sel_hex),
                .blank (sel_blank),
                .dp    (sel_dp),
                .seg   (bank_seg)
            );

            assign seg_cs_next[gi*DPB +: DPB] = cs_bank;
            assign seg_data_next[8*gi +: 8]   = bank_seg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_reg          <= '0;
            idx_reg        <= '0;
            snap_data_reg  <= '0;
            snap_dp_reg    <= '0;
            snap_blank_reg <= 1'b0;
            frame_tick_reg <= 1'b0;
            seg_cs_reg     <= CS_OFF;
            seg_data_reg   <= SEG_OFF;
        end else begin
            p_reg <= p_reg + 1'b1;
            if (p_reg == P_MAX) begin
                idx_reg <= (idx_reg == IDX_MAX) ? '0 : idx_reg + 1'b1;
            end
            if (frame_end) begin
                snap_data_reg  <= data_in;
                snap_dp_reg    <= dp_mask;
                snap_blank_reg <= blank_en;
            end
            frame_tick_reg <= frame_end;
            // Selects and data come from the same (p, idx), so a slot change
            // moves both in one edge and never overlaps two selects.
            seg_cs_reg     <= seg_cs_next ^ CS_OFF;
            seg_data_reg   <= seg_data_next ^ SEG_OFF;
        end
    end

    assign seg_cs     = seg_cs_reg;
    assign seg_data   = seg_data_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        en_inv;
    logic [31:0] data_in;
    logic [7:0]  dp_mask;
    logic        blank_en;
    logic [2:0]  brightness;

    logic [7:0]  seg_cs;
    logic [15:0] seg_data;
    logic        frame_tick;
    logic [7:0]  seg_cs_inv;
    logic [15:0] seg_data_inv;
    logic        frame_tick_inv;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seg_scan_display #(
        .NUM_DIGITS(8), .BANKS(2), .DIV_LOG2(3),
        .CS_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .dp_mask(dp_mask),
        .blank_en(blank_en), .brightness(brightness),
        .seg_cs(seg_cs), .seg_data(seg_data), .frame_tick(frame_tick)
    );

    seg_scan_display #(
        .NUM_DIGITS(8), .BANKS(2), .DIV_LOG2(3),
        .CS_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
    ) dut_inv (
        .clk(clk), .rst(rst), .en(en_inv), .data_in(data_in), .dp_mask(dp_mask),
        .blank_en(blank_en), .brightness(brightness),
        .seg_cs(seg_cs_inv), .seg_data(seg_data_inv), .frame_tick(frame_tick_inv)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vec %0d %s: observed %h expected %h", vectors, tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance until frame_tick is seen (bounded); leaves time at that sample.
    task automatic wait_tick(input string tag);
        int  n   = 0;
        logic got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (frame_tick === 1'b1) got = 1'b1;
        end
        check(tag, {31'd0, got}, 32'd1);
    endtask

    initial begin
        int cnt;

        rst        = 1'b1;
        en         = 1'b1;
        en_inv     = 1'b0;
        data_in    = 32'h76543210;
        dp_mask    = 8'h00;
        blank_en   = 1'b0;
        brightness = 3'd7;
        step(3);

        // Reset state
        check("rst_cs",       {24'd0, seg_cs},       32'h00);
        check("rst_seg",      {16'd0, seg_data},     32'h0000);
        check("rst_tick",     {31'd0, frame_tick},   32'd0);
        check("rst_cs_inv",   {24'd0, seg_cs_inv},   32'hFF);
        check("rst_seg_inv",  {16'd0, seg_data_inv}, 32'hFFFF);

        // Frame 0: zero snapshot
        rst = 1'b0;
        step(1);
        check("f0_s0_cs",  {24'd0, seg_cs},   32'h11);
        check("f0_s0_seg", {16'd0, seg_data}, 32'hFCFC);
        check("inv_en0_cs", {24'd0, seg_cs_inv}, 32'hFF);
        step(24);
        check("f0_s3_cs",  {24'd0, seg_cs},   32'h88);
        check("f0_s3_seg", {16'd0, seg_data}, 32'hFCFC);

        // Frame 1: snapshot of 76543210, input changed mid-frame
        wait_tick("tick1");
        step(1);
        check("tick_pulse", {31'd0, frame_tick}, 32'd0);
        check("f1_s0_cs",  {24'd0, seg_cs},   32'h11);
        check("f1_s0_seg", {16'd0, seg_data}, 32'h66FC);
        step(8);
        check("f1_s1_cs",  {24'd0, seg_cs},   32'h22);
        check("f1_s1_seg", {16'd0, seg_data}, 32'hB660);
        data_in = 32'hFFFFFFFF;
        step(8);
        check("f1_s2_cs",  {24'd0, seg_cs},   32'h44);
        check("f1_s2_seg", {16'd0, seg_data}, 32'hBEDA);
        step(8);
        check("f1_s3_cs",  {24'd0, seg_cs},   32'h88);
        check("f1_s3_seg", {16'd0, seg_data}, 32'hE0F2);
        wait_tick("tick2");
        step(1);
        check("f2_s0_seg", {16'd0, seg_data}, 32'h8E8E);

        // Brightness 3: 4 of 8 cycles per slot
        brightness = 3'd3;
        wait_tick("tick3");
        step(1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (seg_cs[0] === 1'b1) cnt++;
            step(1);
        end
        check("duty3_cs0", cnt, 32'd4);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (seg_cs[5] === 1'b1) cnt++;
            step(1);
        end
        check("duty3_cs5", cnt, 32'd4);

        // Brightness 0: 1 of 8 cycles per slot (measured on slot 3)
        brightness = 3'd0;
        step(8);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (seg_cs[7] === 1'b1) cnt++;
            step(1);
        end
        check("duty0_cs7", cnt, 32'd1);
        brightness = 3'd7;

        // Leading-zero blanking with dp on a blanked digit
        blank_en = 1'b1;
        data_in  = 32'h00000A05;
        dp_mask  = 8'h80;
        wait_tick("tick_blank");
        step(1);
        check("blk_s0_seg", {16'd0, seg_data}, 32'h00B6);
        step(8);
        check("blk_s1_seg", {16'd0, seg_data}, 32'h00FC);
        step(8);
        check("blk_s2_seg", {16'd0, seg_data}, 32'h00EE);
        step(8);
        check("blk_s3_seg", {16'd0, seg_data}, 32'h0100);

        // Reset pulse in the middle of slot 2
        wait_tick("tick_pre_rst");
        step(1 + 8 + 8 + 3);
        rst = 1'b1;
        #1;
        check("arst_cs",     {24'd0, seg_cs},     32'h00);
        check("arst_seg",    {16'd0, seg_data},   32'h0000);
        check("arst_cs_inv", {24'd0, seg_cs_inv}, 32'hFF);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        check("post_rst_cs",  {24'd0, seg_cs},   32'h11);
        check("post_rst_seg", {16'd0, seg_data}, 32'hFCFC);

        // Inverted-polarity instance
        blank_en = 1'b0;
        dp_mask  = 8'h00;
        data_in  = 32'h76543210;
        en_inv   = 1'b1;
        wait_tick("tick_inv");
        step(1);
        check("inv_s0_cs",  {24'd0, seg_cs_inv},   32'hEE);
        check("inv_s0_seg", {16'd0, seg_data_inv}, 32'h9903);
        check("main_s0_seg", {16'd0, seg_data},    32'h66FC);

        // en=0 drops selects within one cycle
        en = 1'b0;
        step(1);
        check("en0_cs",  {24'd0, seg_cs},   32'h00);
        check("en0_seg", {16'd0, seg_data}, 32'h66FC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
